clock_core: RTL

Parametrised time-of-day counter running on the system clock. It generates its own one-second tick from a prescaler, or accepts an external tick. It supports synchronous load with range checking, per-field set buttons, paused running, rollover pulses and a 12-hour view. It sits between the tick source and the display and alarm logic, and keeps the packed hhhhh_mmmmmm_ssssss time format.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/tick_prescaler.sv | 32 +++
 rtl/clock_core.sv | 124 ++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared field widths, limits and helpers for the time-of-day counter.
// Time is packed as {hour[4:0], min[5:0], sec[5:0]}.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int TIME_W = 17;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  // Returns {pm, hour12}; hour 0 and 12 both read as 12.
  function automatic logic [4:0] to_12h(input logic [HOUR_W-1:0] hour);
    logic       pm;
    logic [3:0] h;
    pm = (hour >= 5'd12);
    h  = pm ? 4'(hour - 5'd12) : hour[3:0];
    if (h == 4'd0) h = 4'd12;
    return {pm, h};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle strobe every CLK_FREQ
// enabled cycles; clr restarts the count.
module tick_prescaler #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_FREQ - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clock_core.sv
// Time-of-day counter: field counters, set/load priority and
// registered rollover strobes, with a 12-hour view of the hour.
module clock_core
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter bit EXT_TICK = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              run,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic              inc_hour,
  input  logic              inc_min,
  input  logic              clr_sec,
  output logic [TIME_W-1:0] time_out,
  output logic [3:0]        hour12_out,
  output logic              pm_out,
  output logic              sec_pulse,
  output logic              min_pulse,
  output logic              hour_pulse,
  output logic              day_pulse,
  output logic              load_err
);

  time_t t_q, t_d, ld;
  logic  sp_q, sp_d, mp_q, mp_d;
  logic  hp_q, hp_d, dp_q, dp_d;
  logic  err_q, err_d;
  logic  ptick, tick, ld_ok, pre_clr;

  assign ld    = time_t'(time_in);
  assign ld_ok = (ld.hour <= MAX_HOUR) &&
                 (ld.min  <= MAX_MIN)  &&
                 (ld.sec  <= MAX_SEC);

  // A rejected load must not disturb the prescaler phase.
  assign pre_clr = load ? ld_ok : clr_sec;

  generate
    if (EXT_TICK == 1'b0) begin : g_pre
      tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .clr   (pre_clr),
        .tick  (ptick)
      );
    end else begin : g_ext
      assign ptick = 1'b0;
    end
  endgenerate

  assign tick = EXT_TICK ? (tick_in & run) : ptick;

  always_comb begin
    t_d   = t_q;
    sp_d  = 1'b0;
    mp_d  = 1'b0;
    hp_d  = 1'b0;
    dp_d  = 1'b0;
    err_d = 1'b0;
    if (load) begin
      if (ld_ok) t_d   = ld;
      else       err_d = 1'b1;
    end else if (inc_hour || inc_min || clr_sec) begin
      if (inc_hour)
        t_d.hour = (t_q.hour == MAX_HOUR) ? '0 : t_q.hour + 1'b1;
      if (inc_min)
        t_d.min = (t_q.min == MAX_MIN) ? '0 : t_q.min + 1'b1;
      if (clr_sec)
        t_d.sec = '0;
    end else if (tick) begin
      sp_d = 1'b1;
      if (t_q.sec == MAX_SEC) begin
        t_d.sec = '0;
        mp_d    = 1'b1;
        if (t_q.min == MAX_MIN) begin
          t_d.min = '0;
          hp_d    = 1'b1;
          if (t_q.hour == MAX_HOUR) begin
            t_d.hour = '0;
            dp_d     = 1'b1;
          end else begin
            t_d.hour = t_q.hour + 1'b1;
          end
        end else begin
          t_d.min = t_q.min + 1'b1;
        end
      end else begin
        t_d.sec = t_q.sec + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q   <= '0;
      sp_q  <= 1'b0;
      mp_q  <= 1'b0;
      hp_q  <= 1'b0;
      dp_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      t_q   <= t_d;
      sp_q  <= sp_d;
      mp_q  <= mp_d;
      hp_q  <= hp_d;
      dp_q  <= dp_d;
      err_q <= err_d;
    end
  end

  assign time_out             = t_q;
  assign {pm_out, hour12_out} = to_12h(t_q.hour);
  assign sec_pulse            = sp_q;
  assign min_pulse            = mp_q;
  assign hour_pulse           = hp_q;
  assign day_pulse            = dp_q;
  assign load_err             = err_q;

endmodule
